div_unit: RTL and testbench

- Iterative radix-2 divider. It is the execute-side responder for the div_inst/divsel command that the decode control stage emits for DIV, DIVU, REM and REMU.
- Accepts one operation at a time and computes it over WIDTH cycles.
- Drives busy back to the hazard logic so the pipeline holds. Returns a single-cycle done pulse with the result.
- Implements the RV32M divide-by-zero and signed-overflow results exactly.

---
 rtl/div_unit.sv | 158 +++++++++++++++
 tb/tb_div_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Accepts one operation at a time, iterates WIDTH cycles, and returns a
// one-cycle done pulse with the selected quotient or remainder.
//   clk, rst_n         clock, asynchronous active-low reset
//   div_inst, divsel   request and operation select (001 div, 010 divu, 011 rem, 100 remu)
//   flush              cancels a pending or in-flight operation
//   dividend, divisor  rs1 / rs2 operands
//   busy               stall request to hazard logic (includes the accept cycle)
//   done               one-cycle completion pulse
//   result             quotient or remainder, held until the next done
module div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             div_inst,
    input  logic [2:0]       divsel,
    input  logic             flush,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned      CW        = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CW-1:0]    cnt_q;
    logic             is_rem_q;
    logic             neg_q_q;
    logic             neg_r_q;
    logic             done_q;

    logic             op_valid_c;
    logic             accept_c;
    logic             is_signed_c;
    logic             is_rem_c;
    logic             dvd_neg_c;
    logic             dvs_neg_c;
    logic             div_zero_c;
    logic             ovf_c;
    logic [WIDTH-1:0] dvd_abs_c;
    logic [WIDTH-1:0] dvs_abs_c;
    logic [WIDTH-1:0] fast_q_c;
    logic [WIDTH-1:0] fast_r_c;

    // Request decode, operand magnitudes and fast-path results
    always_comb begin
        op_valid_c  = (divsel >= 3'b001) && (divsel <= 3'b100);
        accept_c    = (state == ST_IDLE) && div_inst && op_valid_c && !flush;
        is_signed_c = (divsel == 3'b001) || (divsel == 3'b011);
        is_rem_c    = (divsel == 3'b011) || (divsel == 3'b100);
        dvd_neg_c   = is_signed_c && dividend[WIDTH-1];
        dvs_neg_c   = is_signed_c && divisor[WIDTH-1];
        dvd_abs_c   = dvd_neg_c ? (~dividend + WIDTH'(1)) : dividend;
        dvs_abs_c   = dvs_neg_c ? (~divisor + WIDTH'(1)) : divisor;
        div_zero_c  = (divisor == '0);
        ovf_c       = is_signed_c && (dividend == MIN_NEG) && (divisor == '1);
        // Divide-by-zero: q = all ones, r = raw dividend. Overflow: q = MIN_NEG, r = 0.
        fast_q_c    = div_zero_c ? '1 : MIN_NEG;
        fast_r_c    = div_zero_c ? dividend : '0;
    end

    logic [WIDTH:0]   rem_shift_c;
    logic [WIDTH:0]   rem_diff_c;
    logic             ge_c;
    logic [WIDTH-1:0] rem_next_c;
    logic [WIDTH-1:0] quo_next_c;
    logic [WIDTH-1:0] q_fix_c;
    logic [WIDTH-1:0] r_fix_c;

    // One restoring shift-subtract step plus the final sign fixup
    always_comb begin
        rem_shift_c = {rem_q, quo_q[WIDTH-1]};
        rem_diff_c  = rem_shift_c - {1'b0, dvs_q};
        // rem_q < dvs_q always holds, so the borrow bit alone tells rem_shift >= divisor
        ge_c        = !rem_diff_c[WIDTH];
        rem_next_c  = ge_c ? rem_diff_c[WIDTH-1:0] : rem_shift_c[WIDTH-1:0];
        quo_next_c  = {quo_q[WIDTH-2:0], ge_c};
        q_fix_c     = (neg_q_q && !is_rem_q) ? (~quo_next_c + WIDTH'(1)) : quo_next_c;
        r_fix_c     = (neg_r_q && is_rem_q) ? (~rem_next_c + WIDTH'(1)) : rem_next_c;
    end

    // busy covers the request cycle so the stage holds before the operation starts
    assign busy = (state == ST_BUSY) || accept_c;
    assign done = done_q && !flush;

    // Control FSM and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            is_rem_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            done_q   <= 1'b0;
            result   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept_c) begin
                        is_rem_q <= is_rem_c;
                        neg_q_q  <= dvd_neg_c ^ dvs_neg_c;
                        neg_r_q  <= dvd_neg_c;
                        cnt_q    <= '0;
                        if (div_zero_c || ovf_c) begin
                            result <= is_rem_c ? fast_r_c : fast_q_c;
                            done_q <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            quo_q <= dvd_abs_c;
                            rem_q <= '0;
                            dvs_q <= dvs_abs_c;
                            state <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else begin
                        quo_q <= quo_next_c;
                        rem_q <= rem_next_c;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == LAST_ITER) begin
                            result <= is_rem_q ? r_fix_c : q_fix_c;
                            done_q <= 1'b1;
                            state  <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized and directed checking of div_unit against an
// arithmetic RV32M reference; busy/done/result are compared every cycle.
module tb_div_unit;

    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             div_inst;
    logic [2:0]       divsel;
    logic             flush;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    int total = 0;
    int bad   = 0;

    logic        exp_busy   = 1'b0;
    logic        exp_done   = 1'b0;
    logic [31:0] exp_result = '0;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .div_inst (div_inst),
        .divsel   (divsel),
        .flush    (flush),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    // RV32M reference result from plain arithmetic
    function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic               ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'b001:  return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sb));
            3'b010:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b011:  return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
            3'b100:  return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit is_fast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bit signed_op;
        signed_op = (op == 3'b001) || (op == 3'b011);
        return (b == 0) || (signed_op && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of all outputs against the expected state
    always @(negedge clk) begin
        check("busy", 32'(busy), 32'(exp_busy));
        check("done", 32'(done), 32'(exp_done));
        check("result", result, exp_result);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_junk();
        div_inst = 1'($urandom_range(0, 1));
        divsel   = 3'($urandom_range(0, 7));
        dividend = $urandom;
        divisor  = $urandom;
        flush    = 1'b0;
    endtask

    // One full operation; flush_at >= 0 flushes during that iteration cycle
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int flush_at, input bit use_lit, input logic [31:0] lit);
        logic [31:0] r;
        bit          fast;
        r    = ref_div(op, a, b);
        fast = is_fast(op, a, b);
        if (use_lit) check("model", r, lit);
        div_inst = 1'b1;
        divsel   = op;
        dividend = a;
        divisor  = b;
        flush    = 1'b0;
        exp_busy = 1'b1;
        exp_done = 1'b0;
        step();
        drive_junk();
        if (!fast) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                exp_busy = 1'b1;
                exp_done = 1'b0;
                if (i == flush_at) begin
                    flush    = 1'b1;
                    div_inst = 1'b0;
                end
                step();
                if (i == flush_at) begin
                    flush    = 1'b0;
                    exp_busy = 1'b0;
                    exp_done = 1'b0;
                    return;
                end
                drive_junk();
            end
        end
        // Done cycle: any request present now must not be accepted
        exp_busy   = 1'b0;
        exp_done   = 1'b1;
        exp_result = use_lit ? lit : r;
        step();
        div_inst = 1'b0;
        exp_busy = 1'b0;
        exp_done = 1'b0;
    endtask

    // A request in IDLE that must be rejected; the following cycle must stay idle
    task automatic idle_reject(input logic [2:0] op, input logic fl);
        div_inst = 1'b1;
        divsel   = op;
        flush    = fl;
        dividend = 32'd77;
        divisor  = 32'd5;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        step();
        div_inst = 1'b0;
        flush    = 1'b0;
        step();
        step();
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          fl;

        rst_n    = 1'b0;
        div_inst = 1'b0;
        divsel   = 3'b000;
        flush    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        run_op(3'b010, 32'd100, 32'd7, -1, 1'b1, 32'd14);
        run_op(3'b100, 32'd100, 32'd7, -1, 1'b1, 32'd2);
        run_op(3'b001, 32'hFFFF_FF9C, 32'd7, -1, 1'b1, 32'hFFFF_FFF2);
        run_op(3'b011, 32'hFFFF_FF9C, 32'd7, -1, 1'b1, 32'hFFFF_FFFE);
        run_op(3'b001, 32'd1234, 32'd0, -1, 1'b1, 32'hFFFF_FFFF);
        run_op(3'b011, 32'd1234, 32'd0, -1, 1'b1, 32'd1234);
        // Flush mid-operation: result keeps 1234, no done
        run_op(3'b010, 32'd50, 32'd5, 10, 1'b0, 32'd0);
        run_op(3'b010, 32'd9, 32'd3, -1, 1'b1, 32'd3);
        run_op(3'b010, 32'd0, 32'd0, -1, 1'b1, 32'hFFFF_FFFF);
        run_op(3'b001, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b1, 32'h8000_0000);
        run_op(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b1, 32'h0);
        run_op(3'b011, 32'd100, 32'hFFFF_FFF9, -1, 1'b1, 32'd2);
        run_op(3'b001, 32'd100, 32'hFFFF_FFF9, -1, 1'b1, 32'hFFFF_FFF2);
        run_op(3'b010, 32'hFFFF_FFFF, 32'd1, -1, 1'b1, 32'hFFFF_FFFF);

        idle_reject(3'b000, 1'b0);
        idle_reject(3'b101, 1'b0);
        idle_reject(3'b111, 1'b0);
        idle_reject(3'b010, 1'b1);

        for (int n = 0; n < 60; n++) begin
            op = 3'($urandom_range(1, 4));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = 32'($urandom_range(0, 1000)); b = 32'($urandom_range(1, 20)); end
                3: b = 32'd0 - 32'($urandom_range(1, 9));
                4: a = 32'd0 - 32'($urandom_range(1, 5000));
                default: ;
            endcase
            fl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 31)) : -1;
            run_op(op, a, b, fl, 1'b0, 32'd0);
        end

        // Asynchronous reset in the middle of an operation
        div_inst = 1'b1;
        divsel   = 3'b010;
        dividend = 32'd1000;
        divisor  = 32'd3;
        exp_busy = 1'b1;
        exp_done = 1'b0;
        step();
        div_inst = 1'b0;
        repeat (12) step();
        #3;
        rst_n      = 1'b0;
        exp_busy   = 1'b0;
        exp_done   = 1'b0;
        exp_result = 32'd0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        repeat (36) step();

        run_op(3'b100, 32'd17, 32'd5, -1, 1'b1, 32'd2);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
